// File: rtl/sr_bank_driver.sv
// Write-side driver for a bank of external SR latch cells: turns accepted data
// words into timed, non-overlapping set/reset pulses and keeps a shadow copy.
module sr_bank_driver #(
    parameter int WIDTH        = 8,
    parameter int PULSE_CYCLES = 2,
    parameter int GAP_CYCLES   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_d,
    output logic [WIDTH-1:0] out_s,
    output logic [WIDTH-1:0] out_r,
    output logic [WIDTH-1:0] out_q,
    output logic             busy
);

    localparam int MAX_CYC = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);
    localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD   = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  s_q, s_d;
    logic [WIDTH-1:0]  r_q, r_d;
    logic [WIDTH-1:0]  shadow_q, shadow_d;
    logic              force_all_q, force_all_d;
    logic [WIDTH-1:0]  set_mask, rst_mask;
    logic              accept;

    // A bit is pulsed only when it differs from the shadow, unless the bank
    // contents are unknown (first write after reset), in which case all bits go.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_mask
        assign set_mask[gi] =  in_d[gi] & (force_all_q | ~shadow_q[gi]);
        assign rst_mask[gi] = ~in_d[gi] & (force_all_q |  shadow_q[gi]);
    end

    assign accept = in_valid && (state_q == IDLE);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        s_d         = s_q;
        r_d         = r_q;
        shadow_d    = shadow_q;
        force_all_d = force_all_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    force_all_d = 1'b0;
                    if (|(set_mask | rst_mask)) begin
                        state_d = PULSE;
                        cnt_d   = PULSE_LOAD;
                        s_d     = set_mask;
                        r_d     = rst_mask;
                    end
                end
            end
            PULSE: begin
                if (cnt_q == '0) begin
                    shadow_d = (shadow_q | s_q) & ~r_q;
                    s_d      = '0;
                    r_d      = '0;
                    if (GAP_CYCLES > 0) begin
                        state_d = GAP;
                        cnt_d   = GAP_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                s_d     = '0;
                r_d     = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            s_q         <= '0;
            r_q         <= '0;
            shadow_q    <= '0;
            force_all_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            s_q         <= s_d;
            r_q         <= r_d;
            shadow_q    <= shadow_d;
            force_all_q <= force_all_d;
        end
    end

    // Pulse outputs come straight from flops so the latch bank never sees glitches.
    assign out_s    = s_q;
    assign out_r    = r_q;
    assign out_q    = shadow_q;
    assign in_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_sr_bank_driver.sv
// Bench for sr_bank_driver: directed scenarios on a PULSE=2/GAP=1 instance and
// random traffic on a PULSE=1/GAP=0 instance, both checked against a scoreboard.
module tb_sr_bank_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       v1, rdy1, busy1;
    logic [7:0] d1, s1, r1, q1;
    logic       v2, rdy2, busy2;
    logic [7:0] d2, s2, r2, q2;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] s;
        logic [7:0] r;
        logic [7:0] q;
    } exp_t;

    exp_t       sb1[$];
    logic [7:0] sb2[$];
    logic [7:0] m1_q;
    bit         m1_force;

    sr_bank_driver #(.WIDTH(8), .PULSE_CYCLES(2), .GAP_CYCLES(1)) u_dut (
        .clk(clk), .reset(reset), .in_valid(v1), .in_ready(rdy1), .in_d(d1),
        .out_s(s1), .out_r(r1), .out_q(q1), .busy(busy1)
    );

    sr_bank_driver #(.WIDTH(8), .PULSE_CYCLES(1), .GAP_CYCLES(0)) u_dut2 (
        .clk(clk), .reset(reset), .in_valid(v2), .in_ready(rdy2), .in_d(d2),
        .out_s(s2), .out_r(r2), .out_q(q2), .busy(busy2)
    );

    // Continuous invariants on both instances.
    always @(negedge clk) begin
        if (!reset) begin
            n_checks++;
            if (((s1 & r1) !== 8'h00) || ((s2 & r2) !== 8'h00)) begin
                n_fail++;
                $display("FAIL inv_overlap s1&r1=%h s2&r2=%h required 00", s1 & r1, s2 & r2);
            end
            n_checks++;
            if ((((s1 | r1) != 8'h00) && !busy1) || (((s2 | r2) != 8'h00) && !busy2)) begin
                n_fail++;
                $display("FAIL inv_pulse_only_busy s1|r1=%h busy1=%b s2|r2=%h busy2=%b", s1 | r1, busy1, s2 | r2, busy2);
            end
            n_checks++;
            if ((rdy1 !== !busy1) || (rdy2 !== !busy2)) begin
                n_fail++;
                $display("FAIL inv_ready rdy1=%b busy1=%b rdy2=%b busy2=%b", rdy1, busy1, rdy2, busy2);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push1(input logic [7:0] d);
        exp_t e;
        if (m1_force) begin
            e.s = d;
            e.r = ~d;
        end else begin
            e.s = d & ~m1_q;
            e.r = ~d & m1_q;
        end
        e.q      = d;
        m1_force = 1'b0;
        m1_q     = d;
        sb1.push_back(e);
    endtask

    // Drives one changing write into u_dut and follows the full pulse/gap sequence.
    task automatic write1(input string name, input logic [7:0] d, input bit hold);
        exp_t e;
        d1 = d;
        v1 = 1'b1;
        n_checks++;
        if (rdy1 !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_ready_at_accept got=%b required=1", name, rdy1);
        end
        push1(d);
        tick;
        v1 = hold;
        e  = sb1.pop_front();
        for (int i = 0; i < 2; i++) begin
            if (hold) d1 = 8'($urandom);
            n_checks++;
            if (s1 !== e.s || r1 !== e.r || busy1 !== 1'b1 || rdy1 !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_pulse%0d s=%h r=%h busy=%b rdy=%b required s=%h r=%h busy=1 rdy=0",
                         name, i, s1, r1, busy1, rdy1, e.s, e.r);
            end
            tick;
        end
        n_checks++;
        if (s1 !== 8'h00 || r1 !== 8'h00 || busy1 !== 1'b1 || rdy1 !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_gap s=%h r=%h busy=%b rdy=%b required s=00 r=00 busy=1 rdy=0",
                     name, s1, r1, busy1, rdy1);
        end
        tick;
        v1 = 1'b0;
        n_checks++;
        if (rdy1 !== 1'b1 || busy1 !== 1'b0 || q1 !== e.q) begin
            n_fail++;
            $display("FAIL %s_done rdy=%b busy=%b q=%h required rdy=1 busy=0 q=%h", name, rdy1, busy1, q1, e.q);
        end
        $display("write %s d=%h s=%h r=%h q=%h", name, d, e.s, e.r, q1);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        v1 = 1'b0; d1 = 8'h00;
        v2 = 1'b0; d2 = 8'h00;
        #3;
        n_checks++;
        if (s1 !== 8'h00 || r1 !== 8'h00 || q1 !== 8'h00 || busy1 !== 1'b0 || rdy1 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state s=%h r=%h q=%h busy=%b rdy=%b required 00 00 00 0 1", s1, r1, q1, busy1, rdy1);
        end
        tick;
        tick;
        reset    = 1'b0;
        m1_q     = 8'h00;
        m1_force = 1'b1;
        tick;
        $display("reset q=%h rdy=%b", q1, rdy1);
    endtask

    task automatic test_first_write;
        write1("first_A5", 8'hA5, 1'b0);
    endtask

    task automatic test_single_bit;
        write1("change_A4", 8'hA4, 1'b0);
    endtask

    task automatic test_no_change;
        d1 = 8'hA4;
        v1 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            push1(8'hA4);
            void'(sb1.pop_front());
            tick;
            n_checks++;
            if (rdy1 !== 1'b1 || busy1 !== 1'b0 || s1 !== 8'h00 || r1 !== 8'h00 || q1 !== 8'hA4) begin
                n_fail++;
                $display("FAIL nochange%0d rdy=%b busy=%b s=%h r=%h q=%h required 1 0 00 00 A4",
                         i, rdy1, busy1, s1, r1, q1);
            end
            $display("write nochange%0d d=A4 q=%h busy=%b", i, q1, busy1);
        end
        v1 = 1'b0;
    endtask

    task automatic test_hold_valid;
        write1("hold_3C", 8'h3C, 1'b1);
    endtask

    task automatic test_reset_mid;
        exp_t e;
        d1 = 8'hF0;
        v1 = 1'b1;
        push1(8'hF0);
        tick;
        v1 = 1'b0;
        e  = sb1.pop_front();
        tick;
        n_checks++;
        if (s1 !== e.s || r1 !== e.r) begin
            n_fail++;
            $display("FAIL midreset_pulse2 s=%h r=%h required s=%h r=%h", s1, r1, e.s, e.r);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (s1 !== 8'h00 || r1 !== 8'h00 || q1 !== 8'h00 || busy1 !== 1'b0 || rdy1 !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_async s=%h r=%h q=%h busy=%b rdy=%b required 00 00 00 0 1", s1, r1, q1, busy1, rdy1);
        end
        tick;
        reset    = 1'b0;
        m1_q     = 8'h00;
        m1_force = 1'b1;
        tick;
        $display("reset mid-pulse q=%h", q1);
        write1("after_reset_00", 8'h00, 1'b0);
    endtask

    task automatic test_random;
        logic [7:0] mq, exp_s, exp_r, exp_q, sm, rm;
        bit         mforce, exp_rdy;
        mq = 8'h00; mforce = 1'b1;
        exp_s = 8'h00; exp_r = 8'h00; exp_q = 8'h00; exp_rdy = 1'b1;
        for (int c = 0; c < 300; c++) begin
            n_checks++;
            if (s2 !== exp_s || r2 !== exp_r || q2 !== exp_q || rdy2 !== exp_rdy) begin
                n_fail++;
                $display("FAIL rand_c%0d s=%h r=%h q=%h rdy=%b required s=%h r=%h q=%h rdy=%b",
                         c, s2, r2, q2, rdy2, exp_s, exp_r, exp_q, exp_rdy);
            end
            v2 = ($urandom_range(0, 3) != 0);
            d2 = (($urandom_range(0, 3) == 0)) ? mq : 8'($urandom);
            if (!exp_rdy) begin
                exp_s = 8'h00; exp_r = 8'h00; exp_rdy = 1'b1;
                exp_q = sb2.pop_front();
            end else if (v2) begin
                sm = mforce ? d2 : (d2 & ~mq);
                rm = mforce ? ~d2 : (~d2 & mq);
                mforce = 1'b0;
                mq     = d2;
                if ((sm | rm) != 8'h00) begin
                    exp_s = sm; exp_r = rm; exp_rdy = 1'b0;
                    sb2.push_back(d2);
                end
                $display("rand accept c=%0d d=%h s=%h r=%h", c, d2, sm, rm);
            end
            tick;
        end
        v2 = 1'b0;
    endtask

    initial begin
        test_reset;
        test_first_write;
        test_single_bit;
        test_no_change;
        test_hold_valid;
        test_reset_mid;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sr_bank_driver.md
Name: sr_bank_driver

Overview:
- Write-side driver for a bank of external SR latch cells.
- Accepts data words over a valid/ready handshake and keeps a shadow copy of the value the bank holds.
- Converts each write into timed, non-overlapping set and reset pulses. Pulses go only to bits that change, except on the first write after reset, which drives every bit.
- Guarantees that no bit ever sees S and R asserted together.

Parameters:
- WIDTH, 8: number of latch cells in the bank (≥1).
- PULSE_CYCLES, 2: clk cycles each set/reset pulse is held high (≥1).
- GAP_CYCLES, 1: clk cycles with all S/R low after a pulse, before the next write is accepted (≥0).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  write request valid.
- in_ready  output  1  driver can accept a write.
- in_d  input  WIDTH  data word to store in the bank.
- out_s  output  WIDTH  per-bit set pulses to the latch bank.
- out_r  output  WIDTH  per-bit reset pulses to the latch bank.
- out_q  output  WIDTH  shadow copy of the bank contents.
- busy  output  1  high while a pulse or gap sequence is in progress.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - out_s=0, out_r=0, out_q=0, busy=0, in_ready=1.
  - State=IDLE, counters=0, force_all=1.
- FSM states: IDLE, PULSE, GAP.
- IDLE:
  - in_ready=1, busy=0, out_s=out_r=0.
  - Accept on in_valid&&in_ready at edge T.
  - Capture the masks:
    - If force_all=1: set_mask=in_d, rst_mask=~in_d.
    - Otherwise: set_mask=in_d&~out_q, rst_mask=~in_d&out_q.
  - Clear force_all.
  - If set_mask|rst_mask is nonzero: go to PULSE, load pulse counter with PULSE_CYCLES-1.
  - If both masks are zero (no-change write): stay in IDLE, no pulse. in_ready stays 1, so back-to-back accepts are allowed. out_q is unchanged.
- PULSE:
  - out_s=set_mask, out_r=rst_mask (registered outputs).
  - Asserted for exactly PULSE_CYCLES cycles, starting the cycle after T.
  - in_ready=0, busy=1.
  - On the last pulse cycle's edge:
    - out_q <= (out_q|set_mask)&~rst_mask, which equals in_d.
    - If GAP_CYCLES>0: go to GAP and load the gap counter. Otherwise go to IDLE.
- GAP:
  - out_s=out_r=0, in_ready=0, busy=1, for exactly GAP_CYCLES cycles, then IDLE.
- Latency for a changing write: accept at T → in_ready next high at T+PULSE_CYCLES+GAP_CYCLES+1.
- Invariants, checked continuously:
  - (out_s&out_r)==0.
  - out_s/out_r are nonzero only in PULSE.
  - out_s/out_r are glitch-free (driven from flops).
  - in_ready == (state==IDLE).
- in_d is sampled only at accept; changes to in_d during PULSE/GAP are ignored.
- in_valid held high while in_ready=0: no accept, no side effects.
- Reset mid-PULSE or mid-GAP:
  - Outputs drop to 0 without waiting for a clock edge.
  - The sequence is aborted; out_q is cleared and force_all is set.
  - The next write after reset drives all bits.
- Counter widths: $clog2(max(PULSE_CYCLES,GAP_CYCLES)+1) bits; no wrap-around is reachable.

Test Plan:
- Reset, then write in_d=8'hA5 (PULSE=2, GAP=1) → out_s=A5 and out_r=5A for 2 cycles starting T+1; 1 gap cycle; in_ready high at T+4; out_q=A5.
- Then write 8'hA4 → only bit0 pulses: out_r=01, out_s=00 for 2 cycles; out_q=A4.
- Write 8'hA4 again (no change) → no pulse, in_ready remains 1, out_q=A4, busy never asserts.
- Hold in_valid high with a changing in_d during PULSE/GAP → no extra accept; the pulse uses the captured word only.
- Assert reset in the second PULSE cycle → out_s/out_r/out_q go to 0 immediately. The next write of 8'h00 pulses out_r=FF (force_all behaviour).
- Random writes with PULSE_CYCLES=1, GAP_CYCLES=0, plus an assertion monitor → (out_s&out_r)==0 always, back-to-back pulses separated by the IDLE cycle, and out_q tracks the last accepted in_d.
